// File: rtl/tcm_dump_reader.sv
// Streams DTCM rows (bank A bytes 0-7, bank B bytes 8-15) out as a byte stream.
// Optional trailing mod-256 checksum byte when TCM_DUMP_CHECKSUM_EN is defined.
module tcm_dump_reader #(
  parameter int AW = 12,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          start,
  input  logic [AW-1:0] start_row,
  input  logic [CW-1:0] row_cnt,
  output logic          busy,
  output logic          done,
  output logic          dtcm_ren,
  output logic [AW-1:0] dtcm_addr,
  input  logic [63:0]   dtcm_a_rdata,
  input  logic [63:0]   dtcm_b_rdata,
  output logic          dout_valid,
  output logic [7:0]    dout_data,
  input  logic          dout_ready,
  output logic [2:0]    o_dbg_state
);

  // Stream handshake: a byte transfers on a cycle where dout_valid and
  // dout_ready are both high; dout_data holds while valid is high and ready low.

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [2:0] FIN  = 3'd5;

  logic [2:0]    r_state;
  logic [AW-1:0] r_row;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_buf;
  logic [3:0]    r_idx;
  logic          w_xfer;
  logic [7:0]    w_byte;
  logic [7:0]    w_sum;

`ifdef TCM_DUMP_CHECKSUM_EN
  logic [7:0]    r_sum;
  assign w_sum = r_sum;
`else
  assign w_sum = 8'h00;
`endif

  assign w_byte      = r_buf[{r_idx, 3'b000} +: 8];
  assign w_xfer      = dout_valid && dout_ready;
  assign busy        = (r_state == READ) || (r_state == WAIT) ||
                       (r_state == SEND) || (r_state == CSUM);
  assign done        = (r_state == FIN);
  assign dtcm_ren    = (r_state == READ);
  assign dtcm_addr   = r_row;
  assign dout_valid  = (r_state == SEND) || (r_state == CSUM);
  assign o_dbg_state = r_state;

  always_comb begin
    dout_data = 8'h00;
    if (r_state == SEND)      dout_data = w_byte;
    else if (r_state == CSUM) dout_data = w_sum;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
`ifdef TCM_DUMP_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row   <= start_row;
            r_cnt   <= row_cnt;
            r_idx   <= '0;
`ifdef TCM_DUMP_CHECKSUM_EN
            r_sum   <= '0;
`endif
            r_state <= (row_cnt != '0) ? READ : FIN;
          end
        end
        READ: r_state <= WAIT;
        WAIT: begin
          r_buf   <= {dtcm_b_rdata, dtcm_a_rdata};
          r_idx   <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (w_xfer) begin
`ifdef TCM_DUMP_CHECKSUM_EN
            r_sum <= r_sum + w_byte;
`endif
            if (r_idx == 4'd15) begin
              r_idx <= '0;
              r_row <= r_row + 1'b1;
              if (r_cnt == CW'(1)) begin
                r_cnt <= '0;
`ifdef TCM_DUMP_CHECKSUM_EN
                r_state <= CSUM;
`else
                r_state <= FIN;
`endif
              end else begin
                r_cnt   <= r_cnt - 1'b1;
                r_state <= READ;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        CSUM: if (w_xfer) r_state <= FIN;
        FIN:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_dump_reader.sv
// Directed table-driven bench for tcm_dump_reader plus hand-written corner sequences.
module tb_tcm_dump_reader;
  logic        CLK;
  logic        RSTn;
  logic        start;
  logic [11:0] start_row;
  logic [15:0] row_cnt;
  logic        busy, done, dtcm_ren, dout_valid, dout_ready;
  logic [11:0] dtcm_addr;
  logic [63:0] dtcm_a_rdata, dtcm_b_rdata;
  logic [7:0]  dout_data;
  logic [2:0]  o_dbg_state;

  tcm_dump_reader #(.AW(12), .CW(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .start_row(start_row), .row_cnt(row_cnt),
    .busy(busy), .done(done), .dtcm_ren(dtcm_ren), .dtcm_addr(dtcm_addr),
    .dtcm_a_rdata(dtcm_a_rdata), .dtcm_b_rdata(dtcm_b_rdata),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready),
    .o_dbg_state(o_dbg_state)
  );

`ifdef TCM_DUMP_CHECKSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  typedef struct {
    logic [11:0] srow;
    logic [15:0] cnt;
    int          rmode;
    bit          inject;
    int          nb;
    logic [7:0]  first;
    logic [7:0]  last;
    logic [11:0] addr0;
    logic [11:0] addr_last;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] mem_a[4096];
  logic [63:0] mem_b[4096];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [11:0] exp_addr_q[$];
  logic [11:0] addr_q[$];
  int total = 0, bad = 0;
  int done_cnt = 0, busy_cyc = 0, ren_seen = 0, valid_seen = 0;
  int rmode = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DTCM model: one-cycle read latency
  always @(posedge CLK) begin
    if (dtcm_ren) begin
      dtcm_a_rdata <= mem_a[dtcm_addr];
      dtcm_b_rdata <= mem_b[dtcm_addr];
    end
  end

  // ready driver: held high or toggled every cycle
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      dout_ready = (rmode == 0) ? 1'b1 : ~dout_ready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (dout_valid && dout_ready) got_q.push_back(dout_data);
      if (dtcm_ren) begin addr_q.push_back(dtcm_addr); ren_seen++; end
      if (dout_valid) valid_seen++;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (stall_prev && dout_valid) check("stall_hold", {24'h0, dout_data}, {24'h0, prev_data});
      stall_prev = dout_valid && !dout_ready;
      prev_data  = dout_data;
    end
  end

  task automatic pulse_start(input logic [11:0] sr, input logic [15:0] c);
    @(posedge CLK);
    #1;
    start = 1'b1; start_row = sr; row_cnt = c;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete(); addr_q.delete(); exp_q.delete(); exp_addr_q.delete();
    done_cnt = 0; busy_cyc = 0; ren_seen = 0; valid_seen = 0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]  sum;
    logic [11:0] a;
    int cyc;
    clear_mon();
    rmode = v.rmode;
    sum = 8'h00;
    for (int r = 0; r < int'(v.cnt); r++) begin
      a = v.srow + 12'(r);
      exp_addr_q.push_back(a);
      for (int k = 0; k < 16; k++) begin
        logic [7:0] b;
        b = (k < 8) ? mem_a[a][8*k +: 8] : mem_b[a][8*(k-8) +: 8];
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
    if (CSUM_ON != 0) exp_q.push_back(sum);
    pulse_start(v.srow, v.cnt);
    if (v.inject) begin
      repeat (8) @(posedge CLK);
      #1;
      start = 1'b1; start_row = 12'h123; row_cnt = 16'd5;
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
    check($sformatf("v%0d_timeout", id), {31'h0, done_cnt != 0}, 32'd1);
    repeat (4) @(negedge CLK);
    check($sformatf("v%0d_done_pulses", id), done_cnt, 32'd1);
    check($sformatf("v%0d_busy_after", id), {31'h0, busy}, 32'd0);
    check($sformatf("v%0d_nbytes", id), got_q.size(), v.nb + CSUM_ON);
    check($sformatf("v%0d_first", id), (got_q.size() > 0) ? {24'h0, got_q[0]} : 32'hFFFF_FFFF,
          {24'h0, v.first});
    check($sformatf("v%0d_last", id), (got_q.size() >= v.nb) ? {24'h0, got_q[v.nb-1]} : 32'hFFFF_FFFF,
          {24'h0, v.last});
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("v%0d_byte%0d", id, i),
            (got_q.size() > i) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    check($sformatf("v%0d_nreads", id), addr_q.size(), exp_addr_q.size());
    check($sformatf("v%0d_addr0", id), (addr_q.size() > 0) ? {20'h0, addr_q[0]} : 32'hFFFF_FFFF,
          {20'h0, v.addr0});
    check($sformatf("v%0d_addr_last", id),
          (addr_q.size() > 0) ? {20'h0, addr_q[addr_q.size()-1]} : 32'hFFFF_FFFF, {20'h0, v.addr_last});
    for (int i = 0; i < exp_addr_q.size(); i++)
      check($sformatf("v%0d_addr%0d", id, i),
            (addr_q.size() > i) ? {20'h0, addr_q[i]} : 32'hFFFF_FFFF, {20'h0, exp_addr_q[i]});
    if (v.rmode == 0)
      check($sformatf("v%0d_busy_cycles", id), busy_cyc, 18 * int'(v.cnt) + CSUM_ON);
    rmode = 0;
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < 4096; r++) begin
      mem_a[r] = 64'h1122334455667788 + 64'(r);
      mem_b[r] = 64'h99AABBCCDDEEFF00 ^ 64'(r);
    end
    mem_a[0] = 64'h0706050403020100;
    mem_b[0] = 64'h0F0E0D0C0B0A0908;
    //          srow     cnt    rmode inj  nb  first  last   addr0    addr_last
    vecs[0] = '{12'h000, 16'd1, 0,    1'b0, 16, 8'h00, 8'h0F, 12'h000, 12'h000};
    vecs[1] = '{12'h000, 16'd1, 1,    1'b0, 16, 8'h00, 8'h0F, 12'h000, 12'h000};
    vecs[2] = '{12'hFFF, 16'd2, 0,    1'b0, 32, 8'h87, 8'h0F, 12'hFFF, 12'h000};
    vecs[3] = '{12'h000, 16'd1, 0,    1'b1, 16, 8'h00, 8'h0F, 12'h000, 12'h000};
    vecs[4] = '{12'h001, 16'd3, 1,    1'b0, 48, 8'h89, 8'h99, 12'h001, 12'h003};

    start = 1'b0; start_row = '0; row_cnt = '0;
    dtcm_a_rdata = '0; dtcm_b_rdata = '0;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_ren", {31'h0, dtcm_ren}, 32'd0);
    check("rst_valid", {31'h0, dout_valid}, 32'd0);
    check("rst_addr", {20'h0, dtcm_addr}, 32'd0);
    check("rst_data", {24'h0, dout_data}, 32'd0);
    check("rst_state", {29'h0, o_dbg_state}, 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    if (CSUM_ON != 0) begin
      run_vec(vecs[0], 5);
      check("csum_byte", (got_q.size() > 16) ? {24'h0, got_q[16]} : 32'hFFFF_FFFF, 32'h78);
    end

    // zero-row dump: done one cycle after start, no reads, no stream
    clear_mon();
    pulse_start(12'h005, 16'd0);
    @(negedge CLK);
    check("zero_done_next", {31'h0, done}, 32'd1);
    check("zero_busy", {31'h0, busy}, 32'd0);
    @(negedge CLK);
    check("zero_done_clear", {31'h0, done}, 32'd0);
    repeat (5) @(negedge CLK);
    check("zero_ren_seen", ren_seen, 32'd0);
    check("zero_valid_seen", valid_seen, 32'd0);
    check("zero_done_cnt", done_cnt, 32'd1);

    // asynchronous reset after byte 5 of row 0
    clear_mon();
    pulse_start(12'h000, 16'd1);
    cyc = 0;
    while (got_q.size() < 6 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
    check("arst_reach_byte5", got_q.size(), 32'd6);
    #1;
    RSTn = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_done", {31'h0, done}, 32'd0);
    check("arst_ren", {31'h0, dtcm_ren}, 32'd0);
    check("arst_valid", {31'h0, dout_valid}, 32'd0);
    check("arst_addr", {20'h0, dtcm_addr}, 32'd0);
    check("arst_data", {24'h0, dout_data}, 32'd0);
    check("arst_state", {29'h0, o_dbg_state}, 32'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_dump_reader.md
TCM_DUMP_READER -- requirements
Module: tcm_dump_reader

Interface
REQ-001 SHALL have parameter AW, default 12, DTCM row address width.
REQ-002 SHALL have parameter CW, default 16, row-count width.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port start_row  input  AW  first DTCM row to read.
REQ-007 SHALL have port row_cnt  input  CW  number of rows to dump.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at dump completion.
REQ-010 SHALL have port dtcm_ren  output  1  read enable to both DTCM banks.
REQ-011 SHALL have port dtcm_addr  output  AW  row address shared by both banks.
REQ-012 SHALL have port dtcm_a_rdata  input  64  bank A row data, valid exactly one cycle after dtcm_ren.
REQ-013 SHALL have port dtcm_b_rdata  input  64  bank B row data, valid exactly one cycle after dtcm_ren.
REQ-014 SHALL have port dout_valid  output  1  byte-stream valid.
REQ-015 SHALL have port dout_data  output  8  byte-stream data.
REQ-016 SHALL have port dout_ready  input  1  byte-stream sink ready.

Function
REQ-017 SHALL implement states IDLE, READ, WAIT, SEND, CSUM, FIN.
REQ-018 SHALL, in IDLE with start high and row_cnt nonzero, latch start_row and row_cnt, assert busy, and go to READ.
REQ-019 SHALL, in IDLE with start high and row_cnt zero, pulse done the next cycle without dtcm_ren or stream output (via FIN).
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL assert dtcm_ren for exactly one cycle in READ with dtcm_addr equal to the current row, then go to WAIT.
REQ-022 SHALL capture both banks' rdata in WAIT into a 128-bit buffer, bank A as bytes 0-7 and bank B as bytes 8-15, little-endian within each bank, then go to SEND.
REQ-023 SHALL present buffer byte k (k = 0..15) on dout_data with dout_valid high in SEND, and advance k only on a cycle where dout_valid and dout_ready are both high.
REQ-024 SHALL hold dout_data stable while dout_valid is high and dout_ready is low.
REQ-025 SHALL, after byte 15 transfers, decrement the remaining count and go to READ if rows remain, else to CSUM (when enabled) or FIN.
REQ-026 SHALL increment the row address modulo 2^AW, wrapping from all-ones to zero.
REQ-027 SHALL assert dout_valid only in SEND and CSUM, and dtcm_ren only in READ.
REQ-028 SHALL, in FIN, pulse done for one cycle, deassert busy, and return to IDLE; start in the FIN cycle is ignored.
REQ-029 SHALL achieve a throughput of one row per 18 cycles with dout_ready held high.

Reset
REQ-030 SHALL, on RSTn low at any time, including mid-dump, force IDLE immediately and drive busy, done, dtcm_ren, and dout_valid to 0, and dtcm_addr and dout_data to 0.
REQ-031 SHALL clear the byte index, row count, buffer, and checksum on reset; an interrupted dump is not resumed.

Configuration
REQ-032 SHALL, with macro TCM_DUMP_CHECKSUM_EN defined, keep an 8-bit running sum (mod 256) of all transferred data bytes and, after the last row, emit it as one extra byte in CSUM under the same valid/ready rules before FIN.
REQ-033 SHALL, without TCM_DUMP_CHECKSUM_EN, omit the CSUM state and sum logic and go directly from the last data byte to FIN.

Verification
REQ-034 SHALL cover: A[0]=0x0706050403020100, B[0]=0x0F0E0D0C0B0A0908, start_row 0, row_cnt 1, ready high -> bytes 0x00..0x0F in order, with checksum enabled one extra byte 0x78, then a single done pulse.
REQ-035 SHALL cover: same stimulus with dout_ready toggled every other cycle -> identical byte sequence, no byte dropped or duplicated, dout_data stable while stalled.
REQ-036 SHALL cover: row_cnt 0 -> done pulse one cycle after start, dtcm_ren never high, dout_valid never high.
REQ-037 SHALL cover: start_row 0xFFF, row_cnt 2 -> dtcm_addr sequence 0xFFF then 0x000, 32 data bytes.
REQ-038 SHALL cover: RSTn pulled low after byte 5 of row 0 -> all outputs 0 asynchronously; a new start after release begins cleanly at byte 0.
REQ-039 SHALL cover: start pulsed during an active dump -> ignored, original dump completes unchanged.
